hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 id_inst  in  32  instruction currently held in IF/ID.
REQ-004 ex_inst  in  32  instruction currently held in ID/EX.
REQ-005 mem_inst, wb_inst  in  32 each  instructions held in EX/MEM and MEM/WB.
REQ-006 mem_regdst, wb_regdst  in  5 each  destination register carried by EX/MEM and MEM/WB.
REQ-007 mem_zero  in  1  Zero flag carried by EX/MEM.
REQ-008 pc_write, ifid_write  out  1 each  enables for PC and IF/ID; 0 = hold.
REQ-009 ifid_flush, idex_nop, exmem_nop  out  1 each  force the named register to load NOP 32'h00000020.
REQ-010 branch_taken  out  1  PC source select for the EX/MEM branch target.
REQ-011 fwd_a, fwd_b  out  2 each  ALU operand forward select: 00 regfile, 10 from EX/MEM, 01 from MEM/WB.
REQ-012 stall_count, flush_count  out  16 each  saturating event counters.
REQ-013 state  out  2  FSM state: 00 RUN, 01 STALL.

Function
REQ-014 Decode fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11].
REQ-015 Writers: opcode 0x00 writes rd; 0x23 (lw) and 0x08 (addi) write rt. Destination 0 never counts as a writer.
REQ-016 Sources: rs for all opcodes except 0x02 (j); rt for 0x00, 0x2B (sw) and 0x04 (beq).
REQ-017 Taken branch: mem opcode 0x04 with mem_zero=1.
REQ-018 On a taken branch, same cycle: branch_taken=1, pc_write=1, ifid_flush=1, idex_nop=1, exmem_nop=1. flush_count increments. Next state is RUN and the stall counter clears.
REQ-019 A taken branch has priority over any stall, including a stall in progress.
REQ-020 Stall cycle outputs: pc_write=0, ifid_write=0, idex_nop=1, ifid_flush=0. stall_count increments once per stall cycle.
REQ-021 Outside stall and flush cycles: pc_write=1, ifid_write=1, all NOP and flush outputs 0.
REQ-022 RUN: a detected hazard (see REQ-030 and REQ-031) with penalty P stalls the current cycle. If P>1, load cnt with P-1 and go to STALL; otherwise stay in RUN.
REQ-023 STALL: stall every cycle and decrement cnt. Return to RUN after the cycle in which cnt==1.
REQ-024 Hazard detection is suppressed in STALL.
REQ-025 Counters saturate at 16'hFFFF and never wrap.
REQ-026 Control outputs are combinational from state and inputs. state, cnt and the counters are registered.

Reset
REQ-027 rst_n=0 asynchronously forces state=RUN, cnt=0, stall_count=0, flush_count=0.
REQ-028 While rst_n=0: pc_write=1, ifid_write=1, ifid_flush=0, idex_nop=0, exmem_nop=0, branch_taken=0, fwd_a=fwd_b=00.
REQ-029 Deassertion mid-program resumes in RUN with no stall carried over.

Configuration
REQ-030 HAZARD_FWD_EN defined: forwarding is enabled.
- fwd_a=10 when an EX/MEM writer's mem_regdst matches ex rs; else 01 when a MEM/WB writer's wb_regdst matches ex rs; else 00.
- fwd_b applies the same rule to ex rt.
- EX/MEM has priority over MEM/WB.
- The only hazard is load-use: ex opcode 0x23 with ex rt matching an id source, P=1.
REQ-031 HAZARD_FWD_EN undefined: forwarding is disabled.
- fwd_a and fwd_b are tied to 00.
- Any id source matching a writer destination is a hazard.
- Penalty: EX writer P=3, MEM writer P=2, WB writer P=1. The largest applicable P is used.

Verification
REQ-032 Reset pulse while in STALL with cnt=2 -> state=00, counters 0, pc_write=1 immediately and asynchronously.
REQ-033 FWD_EN: ex=lw $2,0($1), id=add $3,$2,$4 -> one cycle pc_write=0, idex_nop=1, then RUN; stall_count=1.
REQ-034 FWD_EN: mem=add writing $5, wb writing $5, ex=add $6,$5,$0 -> fwd_a=10, fwd_b=00, no stall.
REQ-035 No FWD_EN: ex=add $7,$1,$1, id=sub $8,$7,$2 -> 3 consecutive stall cycles, stall_count=3.
REQ-036 mem=beq with mem_zero=1 during a STALL -> same cycle flush of all three registers, branch_taken=1, state=RUN, flush_count=1.
REQ-037 Force stall_count to 16'hFFFF via repeated stalls, stall again -> count remains 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for hazard_ctrl: stage instructions and register
// destinations in, stall/flush/forward controls and event counters out.
interface hazard_ctrl_if;
    logic [31:0] id_inst;
    logic [31:0] ex_inst;
    logic [31:0] mem_inst;
    logic [31:0] wb_inst;
    logic [4:0]  mem_regdst;
    logic [4:0]  wb_regdst;
    logic        mem_zero;

    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_nop;
    logic        exmem_nop;
    logic        branch_taken;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_count;
    logic [15:0] flush_count;
    logic [1:0]  state;

    modport master (
        output id_inst, ex_inst, mem_inst, wb_inst, mem_regdst, wb_regdst, mem_zero,
        input  pc_write, ifid_write, ifid_flush, idex_nop, exmem_nop, branch_taken,
        input  fwd_a, fwd_b, stall_count, flush_count, state
    );

    modport slave (
        input  id_inst, ex_inst, mem_inst, wb_inst, mem_regdst, wb_regdst, mem_zero,
        output pc_write, ifid_write, ifid_flush, idex_nop, exmem_nop, branch_taken,
        output fwd_a, fwd_b, stall_count, flush_count, state
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: data-hazard stalls, taken-branch flush and
// operand forwarding. Define HAZARD_FWD_EN to enable forwarding (load-use only).
module hazard_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hif
);

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_STALL = 2'b01;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    function automatic logic writes_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_ADDI);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    genvar gi;

    // Source registers read by the instruction in IF/ID
    logic [5:0] id_op;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;

    assign id_op      = hif.id_inst[31:26];
    assign id_rs      = hif.id_inst[25:21];
    assign id_rt      = hif.id_inst[20:16];
    assign id_uses_rs = (id_op != OP_J);
    assign id_uses_rt = (id_op == OP_RTYPE) || (id_op == OP_SW) || (id_op == OP_BEQ);

    // Writer stages: index 0 = EX (decoded here), 1 = MEM, 2 = WB (carried regdst)
    logic [2:0][5:0] wr_op;
    logic [2:0][4:0] wr_dest;
    logic [2:0]      wr_valid;
    logic [2:0]      id_hit;

    assign wr_op[0]   = hif.ex_inst[31:26];
    assign wr_op[1]   = hif.mem_inst[31:26];
    assign wr_op[2]   = hif.wb_inst[31:26];
    assign wr_dest[0] = (wr_op[0] == OP_RTYPE) ? hif.ex_inst[15:11] : hif.ex_inst[20:16];
    assign wr_dest[1] = hif.mem_regdst;
    assign wr_dest[2] = hif.wb_regdst;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_writer
            assign wr_valid[gi] = writes_op(wr_op[gi]) && (wr_dest[gi] != 5'd0);
            assign id_hit[gi]   = wr_valid[gi] &&
                                  ((id_uses_rs && (id_rs == wr_dest[gi])) ||
                                   (id_uses_rt && (id_rt == wr_dest[gi])));
        end
    endgenerate

    logic [1:0] hazard_p;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;
    logic       unused_bits;

`ifdef HAZARD_FWD_EN
    logic [1:0][4:0] ex_src;
    logic [1:0][1:0] fwd_sel;

    assign ex_src[0] = hif.ex_inst[25:21];
    assign ex_src[1] = hif.ex_inst[20:16];

    // EX/MEM result is younger than MEM/WB, so it wins on a double match
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] = (wr_valid[1] && (wr_dest[1] == ex_src[gi])) ? 2'b10 :
                                 (wr_valid[2] && (wr_dest[2] == ex_src[gi])) ? 2'b01 :
                                                                               2'b00;
        end
    endgenerate

    assign fwd_a_raw   = fwd_sel[0];
    assign fwd_b_raw   = fwd_sel[1];
    assign hazard_p    = ((wr_op[0] == OP_LW) && id_hit[0]) ? 2'd1 : 2'd0;
    assign unused_bits = ^{hif.id_inst[10:0], hif.ex_inst[10:0], hif.mem_inst[25:0],
                           hif.wb_inst[25:0], id_hit[2:1]};
`else
    assign fwd_a_raw   = 2'b00;
    assign fwd_b_raw   = 2'b00;
    // Penalty is the distance the writer still has to travel before write-back
    assign hazard_p    = id_hit[0] ? 2'd3 :
                         id_hit[1] ? 2'd2 :
                         id_hit[2] ? 2'd1 : 2'd0;
    assign unused_bits = ^{hif.id_inst[10:0], hif.ex_inst[25:21], hif.ex_inst[10:0],
                           hif.mem_inst[25:0], hif.wb_inst[25:0]};
`endif

    logic branch_hit;
    assign branch_hit = (wr_op[1] == OP_BEQ) && hif.mem_zero;

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    logic pc_write_c;
    logic ifid_write_c;
    logic ifid_flush_c;
    logic idex_nop_c;
    logic exmem_nop_c;
    logic branch_taken_c;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        stall_count_d  = stall_count_q;
        flush_count_d  = flush_count_q;
        pc_write_c     = 1'b1;
        ifid_write_c   = 1'b1;
        ifid_flush_c   = 1'b0;
        idex_nop_c     = 1'b0;
        exmem_nop_c    = 1'b0;
        branch_taken_c = 1'b0;

        if (branch_hit) begin
            // Redirect wins over any stall, including one already in progress
            branch_taken_c = 1'b1;
            ifid_flush_c   = 1'b1;
            idex_nop_c     = 1'b1;
            exmem_nop_c    = 1'b1;
            flush_count_d  = sat_inc(flush_count_q);
            state_d        = ST_RUN;
            cnt_d          = 2'd0;
        end else if (state_q == ST_STALL) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_nop_c    = 1'b1;
            stall_count_d = sat_inc(stall_count_q);
            cnt_d         = cnt_q - 2'd1;
            if (cnt_q <= 2'd1) begin
                state_d = ST_RUN;
                cnt_d   = 2'd0;
            end
        end else if (hazard_p != 2'd0) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_nop_c    = 1'b1;
            stall_count_d = sat_inc(stall_count_q);
            if (hazard_p > 2'd1) begin
                state_d = ST_STALL;
                cnt_d   = hazard_p - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            cnt_q         <= 2'd0;
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    // Reset also masks the combinational controls so the pipeline free-runs
    assign hif.pc_write     = !rst_n || pc_write_c;
    assign hif.ifid_write   = !rst_n || ifid_write_c;
    assign hif.ifid_flush   = rst_n && ifid_flush_c;
    assign hif.idex_nop     = rst_n && idex_nop_c;
    assign hif.exmem_nop    = rst_n && exmem_nop_c;
    assign hif.branch_taken = rst_n && branch_taken_c;
    assign hif.fwd_a        = rst_n ? fwd_a_raw : 2'b00;
    assign hif.fwd_b        = rst_n ? fwd_b_raw : 2'b00;
    assign hif.stall_count  = stall_count_q;
    assign hif.flush_count  = flush_count_q;
    assign hif.state        = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// against a cycle-level reference model (stall budget, flush and counters).
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if hif();

    hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: remaining stall cycles after the current one, and counts
    int m_stall_left = 0;
    int m_stall_cnt = 0;
    int m_flush_cnt = 0;

    localparam logic [31:0] NOP = 32'h0000_0020;

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic bit is_writer(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h23) || (op == 6'h08);
    endfunction

    function automatic bit reads(input logic [31:0] inst, input logic [4:0] r);
        logic [5:0] op;
        op = inst[31:26];
        return ((op != 6'h02) && (inst[25:21] == r)) ||
               (((op == 6'h00) || (op == 6'h2B) || (op == 6'h04)) && (inst[20:16] == r));
    endfunction

    function automatic int penalty(input logic [31:0] idi, input logic [31:0] exi,
                                   input logic [31:0] memi, input logic [31:0] wbi,
                                   input logic [4:0] md, input logic [4:0] wd);
        int p;
        logic [4:0] exd;
        p = 0;
        exd = (exi[31:26] == 6'h00) ? exi[15:11] : exi[20:16];
`ifdef HAZARD_FWD_EN
        if (exi[31:26] == 6'h23 && exi[20:16] != 5'd0 && reads(idi, exi[20:16])) p = 1;
        if (md == 5'd31 && wd == 5'd31 && memi == wbi) p = p;
`else
        if (is_writer(wbi[31:26]) && wd != 5'd0 && reads(idi, wd)) p = 1;
        if (is_writer(memi[31:26]) && md != 5'd0 && reads(idi, md)) p = 2;
        if (is_writer(exi[31:26]) && exd != 5'd0 && reads(idi, exd)) p = 3;
`endif
        return p;
    endfunction

`ifdef HAZARD_FWD_EN
    function automatic logic [1:0] fwd_model(input logic [4:0] r, input logic [31:0] memi,
                                             input logic [31:0] wbi, input logic [4:0] md,
                                             input logic [4:0] wd);
        if (is_writer(memi[31:26]) && md != 5'd0 && md == r) return 2'b10;
        if (is_writer(wbi[31:26]) && wd != 5'd0 && wd == r) return 2'b01;
        return 2'b00;
    endfunction
`endif

    function automatic logic [31:0] rand_inst();
        logic [5:0] op;
        case ($urandom_range(0, 7))
            0, 1:    op = 6'h00;
            2:       op = 6'h23;
            3:       op = 6'h08;
            4:       op = 6'h2B;
            5:       op = 6'h04;
            6:       op = 6'h02;
            default: op = 6'h0D;
        endcase
        return {op, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                5'($urandom_range(0, 5)), 11'($urandom_range(0, 2047))};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pipeline cycle: drive, check combinational outputs mid-cycle, clock, advance model
    task automatic step(input logic [31:0] idi, input logic [31:0] exi,
                        input logic [31:0] memi, input logic [31:0] wbi,
                        input logic [4:0] md, input logic [4:0] wd,
                        input logic mz, input bit do_chk);
        bit br, stl;
        int p;
        logic [1:0] efa, efb;
        hif.id_inst = idi; hif.ex_inst = exi; hif.mem_inst = memi; hif.wb_inst = wbi;
        hif.mem_regdst = md; hif.wb_regdst = wd; hif.mem_zero = mz;
        br  = (memi[31:26] == 6'h04) && mz;
        p   = (br || m_stall_left > 0) ? 0 : penalty(idi, exi, memi, wbi, md, wd);
        stl = !br && (m_stall_left > 0 || p > 0);
`ifdef HAZARD_FWD_EN
        efa = fwd_model(exi[25:21], memi, wbi, md, wd);
        efb = fwd_model(exi[20:16], memi, wbi, md, wd);
`else
        efa = 2'b00;
        efb = 2'b00;
`endif
        @(negedge clk);
        if (do_chk) begin
            check("pc_write", {31'd0, hif.pc_write}, {31'd0, !stl});
            check("ifid_write", {31'd0, hif.ifid_write}, {31'd0, !stl});
            check("ifid_flush", {31'd0, hif.ifid_flush}, {31'd0, br});
            check("idex_nop", {31'd0, hif.idex_nop}, {31'd0, br || stl});
            check("exmem_nop", {31'd0, hif.exmem_nop}, {31'd0, br});
            check("branch_taken", {31'd0, hif.branch_taken}, {31'd0, br});
            check("fwd_a", {30'd0, hif.fwd_a}, {30'd0, efa});
            check("fwd_b", {30'd0, hif.fwd_b}, {30'd0, efb});
            check("state", {30'd0, hif.state}, (m_stall_left > 0) ? 32'd1 : 32'd0);
            check("stall_count", {16'd0, hif.stall_count}, 32'(m_stall_cnt));
            check("flush_count", {16'd0, hif.flush_count}, 32'(m_flush_cnt));
        end
        @(posedge clk);
        #1;
        if (br) begin
            m_stall_left = 0;
            if (m_flush_cnt < 65535) m_flush_cnt++;
        end else if (stl) begin
            m_stall_left = (m_stall_left > 0) ? m_stall_left - 1 : p - 1;
            if (m_stall_cnt < 65535) m_stall_cnt++;
        end
    endtask

    // Asynchronous reset pulse with hazard, forward and branch conditions all present
    task automatic do_reset();
        hif.id_inst = rtype(5'd3, 5'd6, 5'd6, 6'h20);
        hif.ex_inst = rtype(5'd6, 5'd5, 5'd5, 6'h20);
        hif.mem_inst = itype(6'h04, 5'd1, 5'd1, 16'd4);
        hif.wb_inst = rtype(5'd5, 5'd1, 5'd2, 6'h20);
        hif.mem_regdst = 5'd0; hif.wb_regdst = 5'd5; hif.mem_zero = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_state", {30'd0, hif.state}, 32'd0);
        check("rst_pc_write", {31'd0, hif.pc_write}, 32'd1);
        check("rst_ifid_write", {31'd0, hif.ifid_write}, 32'd1);
        check("rst_ifid_flush", {31'd0, hif.ifid_flush}, 32'd0);
        check("rst_idex_nop", {31'd0, hif.idex_nop}, 32'd0);
        check("rst_exmem_nop", {31'd0, hif.exmem_nop}, 32'd0);
        check("rst_branch_taken", {31'd0, hif.branch_taken}, 32'd0);
        check("rst_fwd_a", {30'd0, hif.fwd_a}, 32'd0);
        check("rst_fwd_b", {30'd0, hif.fwd_b}, 32'd0);
        check("rst_stall_count", {16'd0, hif.stall_count}, 32'd0);
        check("rst_flush_count", {16'd0, hif.flush_count}, 32'd0);
        hif.id_inst = NOP; hif.ex_inst = NOP; hif.mem_inst = NOP; hif.wb_inst = NOP;
        hif.mem_regdst = 5'd0; hif.wb_regdst = 5'd0; hif.mem_zero = 1'b0;
        m_stall_left = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] lw2, use2, add7, sub8, beq_t;

    initial begin
        lw2   = itype(6'h23, 5'd1, 5'd2, 16'd0);
        use2  = rtype(5'd3, 5'd2, 5'd4, 6'h20);
        add7  = rtype(5'd7, 5'd1, 5'd1, 6'h20);
        sub8  = rtype(5'd8, 5'd7, 5'd2, 6'h22);
        beq_t = itype(6'h04, 5'd1, 5'd1, 16'd8);
        #1;
        do_reset();

`ifdef HAZARD_FWD_EN
        // Load-use: one stall cycle then back to RUN
        step(use2, lw2, NOP, NOP, 5'd0, 5'd0, 1'b0, 1'b1);
        check("lu_stall_count", {16'd0, hif.stall_count}, 32'd1);
        check("lu_state", {30'd0, hif.state}, 32'd0);
        step(NOP, use2, NOP, NOP, 5'd0, 5'd0, 1'b0, 1'b1);
        // EX/MEM and MEM/WB both write $5: younger result selected
        step(NOP, rtype(5'd6, 5'd5, 5'd0, 6'h20), rtype(5'd5, 5'd1, 5'd2, 6'h20),
             rtype(5'd5, 5'd3, 5'd4, 6'h20), 5'd5, 5'd5, 1'b0, 1'b1);
        check("fwd_stall_free", {16'd0, hif.stall_count}, 32'd1);
        // Taken branch beats a load-use stall in the same cycle
        step(use2, lw2, beq_t, NOP, 5'd0, 5'd0, 1'b1, 1'b1);
        check("br_flush_count", {16'd0, hif.flush_count}, 32'd1);
        check("br_state", {30'd0, hif.state}, 32'd0);
        do_reset();
`else
        // EX writer used in ID: three consecutive stall cycles
        step(sub8, add7, NOP, NOP, 5'd0, 5'd0, 1'b0, 1'b1);
        step(sub8, add7, NOP, NOP, 5'd0, 5'd0, 1'b0, 1'b1);
        step(sub8, add7, NOP, NOP, 5'd0, 5'd0, 1'b0, 1'b1);
        check("ex_stall_count", {16'd0, hif.stall_count}, 32'd3);
        check("ex_state", {30'd0, hif.state}, 32'd0);
        step(NOP, sub8, NOP, NOP, 5'd0, 5'd0, 1'b0, 1'b1);
        // MEM writer: penalty 2
        step(sub8, NOP, add7, NOP, 5'd7, 5'd0, 1'b0, 1'b1);
        step(sub8, NOP, add7, NOP, 5'd7, 5'd0, 1'b0, 1'b1);
        check("mem_stall_count", {16'd0, hif.stall_count}, 32'd5);
        // Reset pulse in STALL with two cycles still owed
        step(sub8, add7, NOP, NOP, 5'd0, 5'd0, 1'b0, 1'b1);
        check("pre_rst_state", {30'd0, hif.state}, 32'd1);
        do_reset();
        // Taken branch during STALL
        step(sub8, add7, NOP, NOP, 5'd0, 5'd0, 1'b0, 1'b1);
        step(sub8, add7, beq_t, NOP, 5'd0, 5'd0, 1'b1, 1'b1);
        check("br_flush_count", {16'd0, hif.flush_count}, 32'd1);
        check("br_state", {30'd0, hif.state}, 32'd0);
        step(NOP, NOP, NOP, NOP, 5'd0, 5'd0, 1'b0, 1'b1);
        do_reset();
`endif

        for (int i = 0; i < 400; i++) begin
            step(rand_inst(), rand_inst(), rand_inst(), rand_inst(),
                 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                 1'($urandom_range(0, 1)), 1'b1);
        end

        // Drive stall_count into saturation, then stall once more
        do_reset();
        for (int i = 0; i < 65540; i++) begin
            step(use2, lw2, NOP, NOP, 5'd0, 5'd0, 1'b0, 1'b0);
        end
        check("sat_stall_count", {16'd0, hif.stall_count}, 32'h0000_FFFF);
        step(use2, lw2, NOP, NOP, 5'd0, 5'd0, 1'b0, 1'b1);
        check("sat_stall_hold", {16'd0, hif.stall_count}, 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
